// File: rtl/operand_stager_pkg.sv
// Shared types and constants for the operand stager: FSM states,
// beat-index constants and default operand/bus widths.
package operand_stager_pkg;

   localparam int DEF_DATAW = 64;
   localparam int DEF_BUSW  = 32;
   localparam int LATW      = 4;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      WAIT = 2'd1,
      OUT  = 2'd2
   } state_e;

   localparam logic [2:0] BEAT_A_LO = 3'd0;
   localparam logic [2:0] BEAT_A_HI = 3'd1;
   localparam logic [2:0] BEAT_B_LO = 3'd2;
   localparam logic [2:0] BEAT_B_HI = 3'd3;
   localparam logic [2:0] BEAT_C_LO = 3'd4;
   localparam logic [2:0] BEAT_C_HI = 3'd5;

endpackage

// File: rtl/operand_beat_asm.sv
// Beat assembly: a 3-bit beat counter steering each accepted bus beat
// into one half of operand a, b or c. Untouched halves keep their value.
module operand_beat_asm
   import operand_stager_pkg::*;
#(
   parameter int DATAW = DEF_DATAW,
   parameter int BUSW  = DEF_BUSW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             beat_en,
   input  logic [BUSW-1:0]  beat_data,
   output logic [DATAW-1:0] a,
   output logic [DATAW-1:0] b,
   output logic [DATAW-1:0] c,
   output logic             last_beat
);

   logic [2:0]       beat_q, beat_d;
   logic [DATAW-1:0] a_q, a_d;
   logic [DATAW-1:0] b_q, b_d;
   logic [DATAW-1:0] c_q, c_d;
   logic             last_beat_s;

   // Decode the current beat index into a half-word write and advance the counter
   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      beat_d      = beat_q;
      last_beat_s = 1'b0;
      if (beat_en) begin
         case (beat_q)
            BEAT_A_LO: a_d[0    +: BUSW] = beat_data;
            BEAT_A_HI: a_d[BUSW +: BUSW] = beat_data;
            BEAT_B_LO: b_d[0    +: BUSW] = beat_data;
            BEAT_B_HI: b_d[BUSW +: BUSW] = beat_data;
            BEAT_C_LO: c_d[0    +: BUSW] = beat_data;
            BEAT_C_HI: c_d[BUSW +: BUSW] = beat_data;
            default:   a_d = a_q;
         endcase
         // Out-of-range counter values recover to the first beat
         if (beat_q >= BEAT_C_HI) begin
            beat_d      = BEAT_A_LO;
            last_beat_s = (beat_q == BEAT_C_HI);
         end else begin
            beat_d = beat_q + 3'd1;
         end
      end else begin
         beat_d = beat_q;
      end
   end

   // Beat counter and operand registers
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_q <= BEAT_A_LO;
         a_q    <= {DATAW{1'b0}};
         b_q    <= {DATAW{1'b0}};
         c_q    <= {DATAW{1'b0}};
      end else begin
         beat_q <= beat_d;
         a_q    <= a_d;
         b_q    <= b_d;
         c_q    <= c_d;
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign c         = c_q;
   assign last_beat = last_beat_s;

endmodule

// File: rtl/operand_stager.sv
// Operand stager: collects six bus beats into operands a/b/c, waits LAT
// cycles for the downstream datapath, then presents res_x/res_z on a
// valid/ready handshake. Optional macro OPERAND_STAGER_TXCNT_EN enables
// the completed-transaction counter on txn_count.
module operand_stager
   import operand_stager_pkg::*;
#(
   parameter int DATAW = DEF_DATAW,
   parameter int BUSW  = DEF_BUSW,
   parameter int LAT   = 2
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [BUSW-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [DATAW-1:0] a,
   output logic [DATAW-1:0] b,
   output logic [DATAW-1:0] c,
   input  logic [BUSW-1:0]  res_x,
   input  logic [BUSW-1:0]  res_z,
   output logic [BUSW-1:0]  out_x,
   output logic [BUSW-1:0]  out_z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      txn_count
);

   localparam logic [LATW-1:0] LAT_INIT = LATW'(LAT);

   state_e          state_q, state_d;
   logic [LATW-1:0] lat_q, lat_d;
   logic [BUSW-1:0] out_x_q, out_x_d;
   logic [BUSW-1:0] out_z_q, out_z_d;
   logic            accept_s;
   logic            last_beat_s;

   assign in_ready = (state_q == LOAD);
   assign accept_s = in_valid && (state_q == LOAD);

   operand_beat_asm #(
      .DATAW (DATAW),
      .BUSW  (BUSW)
   ) u_beat_asm (
      .clk       (Clk),
      .rst       (Rst),
      .beat_en   (accept_s),
      .beat_data (in_data),
      .a         (a),
      .b         (b),
      .c         (c),
      .last_beat (last_beat_s)
   );

   // Next-state, latency countdown and result capture
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      out_x_d = out_x_q;
      out_z_d = out_z_q;
      case (state_q)
         LOAD: begin
            if (last_beat_s) begin
               state_d = WAIT;
               lat_d   = LAT_INIT;
            end else begin
               state_d = LOAD;
            end
         end
         WAIT: begin
            // Capture one edge after the countdown reaches zero
            if (lat_q == {LATW{1'b0}}) begin
               out_x_d = res_x;
               out_z_d = res_z;
               state_d = OUT;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         OUT: begin
            if (out_ready) begin
               state_d = LOAD;
            end else begin
               state_d = OUT;
            end
         end
         default: begin
            state_d = LOAD;
            lat_d   = {LATW{1'b0}};
         end
      endcase
   end

   // State, latency counter and captured results
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= LOAD;
         lat_q   <= {LATW{1'b0}};
         out_x_q <= {BUSW{1'b0}};
         out_z_q <= {BUSW{1'b0}};
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         out_x_q <= out_x_d;
         out_z_q <= out_z_d;
      end
   end

   assign out_x     = out_x_q;
   assign out_z     = out_z_q;
   assign out_valid = (state_q == OUT);

`ifdef OPERAND_STAGER_TXCNT_EN
   logic [15:0] txn_q, txn_d;

   // Count completed result handshakes, wrapping at 16 bits
   always_comb begin
      if ((state_q == OUT) && out_ready) begin
         txn_d = txn_q + 16'd1;
      end else begin
         txn_d = txn_q;
      end
   end

   // Transaction counter register
   always_ff @(posedge Clk) begin
      if (Rst) begin
         txn_q <= 16'd0;
      end else begin
         txn_q <= txn_d;
      end
   end

   assign txn_count = txn_q;
`else
   assign txn_count = 16'd0;
`endif

endmodule

// File: tb/tb_operand_stager.sv
// Self-checking bench for operand_stager with a behavioural operand model.
module tb_operand_stager;

   localparam int DATAW = 64;
   localparam int BUSW  = 32;
   localparam int LAT   = 2;

   logic             clk = 1'b0;
   logic             Rst;
   logic [BUSW-1:0]  in_data;
   logic             in_valid;
   logic             in_ready;
   logic [DATAW-1:0] a, b, c;
   logic [BUSW-1:0]  res_x, res_z;
   logic [BUSW-1:0]  out_x, out_z;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      txn_count;

   logic [63:0] m_op [3];
   int          m_beat;
   logic [15:0] m_txn;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   operand_stager #(.DATAW(DATAW), .BUSW(BUSW), .LAT(LAT)) dut (
      .Clk(clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .a(a), .b(b), .c(c), .res_x(res_x), .res_z(res_z),
      .out_x(out_x), .out_z(out_z), .out_valid(out_valid),
      .out_ready(out_ready), .txn_count(txn_count)
   );

   task automatic model_clear();
      m_op[0] = 64'd0; m_op[1] = 64'd0; m_op[2] = 64'd0;
      m_beat  = 0;
      m_txn   = 16'd0;
   endtask

   // Reset for one edge, then check the post-reset state
   task automatic test_reset();
      @(negedge clk);
      Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      Rst = 1'b0;
      model_clear();
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_tests++;
      if ({a, b, c} !== 192'd0) begin n_fail++; $display("FAIL reset_abc: got %h expected 0", {a, b, c}); end
      n_tests++;
      if ({out_x, out_z} !== 64'd0) begin n_fail++; $display("FAIL reset_out_xz: got %h expected 0", {out_x, out_z}); end
      n_tests++;
      if (txn_count !== 16'd0) begin n_fail++; $display("FAIL reset_txn: got %0d expected 0", txn_count); end
   endtask

   // Send n beats. mode 0 random data, 1 all ones, 2 pattern 1,0,2,0,3,0.
   // gaps 0 none, 1 random in_valid, 2 alternating 1,0,1,0.
   task automatic send_beats(input int n, input int mode, input int gaps);
      int          sent = 0;
      bit          tog  = 1'b1;
      bit          v;
      logic [31:0] d;
      while (sent < n) begin
         @(negedge clk);
         n_tests++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL load_in_ready: got %b expected 1", in_ready); end
         n_tests++;
         if ({a, b, c} !== {m_op[0], m_op[1], m_op[2]}) begin
            n_fail++; $display("FAIL load_abc: got %h expected %h", {a, b, c}, {m_op[0], m_op[1], m_op[2]});
         end
         if (gaps == 0) v = 1'b1;
         else if (gaps == 1) v = ($urandom_range(0, 1) == 1);
         else v = tog;
         tog = ~tog;
         if (v) begin
            if (mode == 0) d = $urandom;
            else if (mode == 1) d = 32'hFFFF_FFFF;
            else d = (m_beat % 2 == 0) ? 32'(m_beat / 2 + 1) : 32'd0;
            in_data  = d;
            in_valid = 1'b1;
            m_op[m_beat / 2][(m_beat % 2) * 32 +: 32] = d;
            m_beat = (m_beat + 1) % 6;
            sent++;
         end else begin
            in_valid = 1'b0;
            in_data  = $urandom;
         end
      end
   endtask

   // After the sixth beat: latency wait, capture, then handshake after 'delay' cycles
   task automatic finish_txn(input logic [31:0] rx, input logic [31:0] rz,
                             input int delay, input bit rst_in_out);
      @(negedge clk);
      in_valid = 1'b0; res_x = rx; res_z = rz;
      for (int k = 0; k <= LAT; k++) begin
         if (k > 0) @(negedge clk);
         in_valid = ($urandom_range(0, 1) == 1);
         in_data  = $urandom;
         n_tests++;
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL wait_in_ready: got %b expected 0 (k=%0d)", in_ready, k); end
         n_tests++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wait_out_valid: got %b expected 0 (k=%0d)", out_valid, k); end
         n_tests++;
         if ({a, b, c} !== {m_op[0], m_op[1], m_op[2]}) begin
            n_fail++; $display("FAIL wait_abc: got %h expected %h", {a, b, c}, {m_op[0], m_op[1], m_op[2]});
         end
      end
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL out_valid: got %b expected 1", out_valid); end
      n_tests++;
      if ({out_x, out_z} !== {rx, rz}) begin n_fail++; $display("FAIL capture: got %h expected %h", {out_x, out_z}, {rx, rz}); end
      res_x = $urandom; res_z = $urandom;
      if (rst_in_out) begin
         out_ready = 1'b1; Rst = 1'b1;
         @(negedge clk);
         Rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
         model_clear();
         n_tests++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
         n_tests++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_out_in_ready: got %b expected 1", in_ready); end
         n_tests++;
         if (txn_count !== 16'd0) begin n_fail++; $display("FAIL rst_out_txn: got %0d expected 0", txn_count); end
         n_tests++;
         if ({a, b, c, out_x, out_z} !== 256'd0) begin n_fail++; $display("FAIL rst_out_clear: got %h expected 0", {a, b, c, out_x, out_z}); end
         return;
      end
      for (int d = 0; d < delay; d++) begin
         @(negedge clk);
         n_tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL out_hold_hs: got valid=%b ready=%b expected valid=1 ready=0", out_valid, in_ready);
         end
         n_tests++;
         if ({out_x, out_z} !== {rx, rz}) begin n_fail++; $display("FAIL out_hold: got %h expected %h", {out_x, out_z}, {rx, rz}); end
         n_tests++;
         if ({a, b, c} !== {m_op[0], m_op[1], m_op[2]}) begin
            n_fail++; $display("FAIL out_abc: got %h expected %h", {a, b, c}, {m_op[0], m_op[1], m_op[2]});
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0;
`ifdef OPERAND_STAGER_TXCNT_EN
      m_txn = m_txn + 16'd1;
`endif
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL done_out_valid: got %b expected 0", out_valid); end
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL done_in_ready: got %b expected 1", in_ready); end
      n_tests++;
      if (txn_count !== m_txn) begin n_fail++; $display("FAIL txn_count: got %0d expected %0d", txn_count, m_txn); end
   endtask

   task automatic test_basic();
      send_beats(6, 2, 0);
      finish_txn($urandom, $urandom, 0, 1'b0);
      n_tests++;
      if (a !== 64'd1 || b !== 64'd2 || c !== 64'd3) begin
         n_fail++; $display("FAIL basic_abc: got %h %h %h expected 1 2 3", a, b, c);
      end
   endtask

   task automatic test_hold();
      send_beats(6, 0, 0);
      finish_txn(32'hDEADBEEF, 32'h12345678, 5, 1'b0);
   endtask

   task automatic test_toggle_valid();
      send_beats(6, 0, 2);
      finish_txn($urandom, $urandom, 1, 1'b0);
   endtask

   task automatic test_mid_reset();
      send_beats(3, 0, 0);
      test_reset();
      send_beats(6, 1, 0);
      finish_txn($urandom, $urandom, 0, 1'b0);
      n_tests++;
      if ({a, b, c} !== {192{1'b1}}) begin n_fail++; $display("FAIL mid_reset_abc: got %h expected all ones", {a, b, c}); end
   endtask

   task automatic test_reset_in_out();
      send_beats(6, 0, 0);
      finish_txn($urandom, $urandom, 0, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 4; t++) begin
         send_beats(6, 0, 0);
         finish_txn($urandom, $urandom, 0, 1'b0);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 15; t++) begin
         send_beats(6, 0, 1);
         finish_txn($urandom, $urandom, $urandom_range(0, 4), 1'b0);
      end
   endtask

   initial begin
      Rst = 1'b1; in_data = 32'd0; in_valid = 1'b0; out_ready = 1'b0;
      res_x = 32'd0; res_z = 32'd0;
      model_clear();
      repeat (2) @(posedge clk);
      test_reset();
      test_basic();
      test_hold();
      test_toggle_valid();
      test_mid_reset();
      test_reset_in_out();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
